// File: rtl/fpu_seq_unit.sv
// Multi-cycle single-precision ADD/SUB/MUL unit on a strobe handshake.
// Denormals flush to zero and every result is truncated (round toward zero).
module fpu_seq_unit (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_value_i,
    input  logic [31:0] b_value_i,
    input  logic        exec_strobe_i,
    output logic [31:0] z_value_o,
    output logic        done_strobe_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] OP     = 3'd2;
    localparam logic [2:0] NORM   = 3'd3;
    localparam logic [2:0] PACK   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [3:0]  OP_ADD = 4'd0;
    localparam logic [3:0]  OP_SUB = 4'd1;
    localparam logic [3:0]  OP_MUL = 4'd2;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    logic [2:0]         state;
    logic [3:0]         op_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               sign_a;
    logic               sign_b;
    logic [7:0]         exp_a;
    logic [7:0]         exp_b;
    logic [23:0]        man_a;
    logic [23:0]        man_b;
    logic               sign_z;
    logic signed [9:0]  exp_z;
    logic [24:0]        man_z;

    logic        u_sa;
    logic        u_sb;
    logic        u_sbe;
    logic [7:0]  u_ea;
    logic [7:0]  u_eb;
    logic [22:0] u_fa;
    logic [22:0] u_fb;
    logic        nan_a;
    logic        nan_b;
    logic        inf_a;
    logic        inf_b;
    logic        zero_a;
    logic        zero_b;
    logic        special_hit;
    logic [31:0] special_z;

    assign u_sa   = a_r[31];
    assign u_sb   = b_r[31];
    assign u_sbe  = b_r[31] ^ (op_r == OP_SUB);
    assign u_ea   = a_r[30:23];
    assign u_eb   = b_r[30:23];
    assign u_fa   = a_r[22:0];
    assign u_fb   = b_r[22:0];
    assign nan_a  = (u_ea == 8'hFF) && (u_fa != 23'd0);
    assign nan_b  = (u_eb == 8'hFF) && (u_fb != 23'd0);
    assign inf_a  = (u_ea == 8'hFF) && (u_fa == 23'd0);
    assign inf_b  = (u_eb == 8'hFF) && (u_fb == 23'd0);
    assign zero_a = (u_ea == 8'd0);
    assign zero_b = (u_eb == 8'd0);

    // Operands that short-circuit straight to DONE without any arithmetic
    always_comb begin
        special_hit = 1'b1;
        special_z   = 32'h0000_0000;
        if (op_r > OP_MUL) begin
            special_z = 32'h0000_0000;
        end else if (nan_a || nan_b) begin
            special_z = QNAN;
        end else if (op_r == OP_MUL) begin
            if ((inf_a && zero_b) || (inf_b && zero_a))
                special_z = QNAN;
            else if (inf_a || inf_b)
                special_z = {u_sa ^ u_sb, 8'hFF, 23'd0};
            else if (zero_a || zero_b)
                special_z = {u_sa ^ u_sb, 31'd0};
            else
                special_hit = 1'b0;
        end else begin
            if (inf_a && inf_b)
                special_z = (u_sa != u_sbe) ? QNAN : {u_sa, 8'hFF, 23'd0};
            else if (inf_a)
                special_z = {u_sa, 8'hFF, 23'd0};
            else if (inf_b)
                special_z = {u_sbe, 8'hFF, 23'd0};
            else if (zero_a && zero_b)
                special_z = {u_sa & u_sbe, 31'd0};
            else if (zero_a)
                special_z = {u_sbe, b_r[30:0]};
            else if (zero_b)
                special_z = a_r;
            else
                special_hit = 1'b0;
        end
    end

    logic               a_big;
    logic [7:0]         big_e;
    logic [7:0]         small_e;
    logic [23:0]        big_m;
    logic [23:0]        small_m;
    logic               big_s;
    logic               small_s;
    logic [7:0]         exp_diff;
    logic [23:0]        aligned;
    logic [24:0]        sum;
    logic [47:0]        product;
    logic [9:0]         mul_exp;
    logic [23:0]        prod_m;
    logic signed [9:0]  prod_e;

    // sign_b already carries the SUB inversion, so the adder only compares signs
    always_comb begin
        a_big    = {exp_a, man_a} >= {exp_b, man_b};
        big_e    = a_big ? exp_a  : exp_b;
        small_e  = a_big ? exp_b  : exp_a;
        big_m    = a_big ? man_a  : man_b;
        small_m  = a_big ? man_b  : man_a;
        big_s    = a_big ? sign_a : sign_b;
        small_s  = a_big ? sign_b : sign_a;
        exp_diff = big_e - small_e;
        aligned  = (exp_diff > 8'd24) ? 24'd0 : (small_m >> exp_diff);
        if (big_s == small_s)
            sum = {1'b0, big_m} + {1'b0, aligned};
        else
            sum = {1'b0, big_m} - {1'b0, aligned};

        product = 48'(man_a) * 48'(man_b);
        mul_exp = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
        if (product[47]) begin
            prod_m = 24'(product >> 24);
            prod_e = $signed(mul_exp + 10'd1);
        end else begin
            prod_m = 24'(product >> 23);
            prod_e = $signed(mul_exp);
        end
    end

    assign done_strobe_o = (state == DONE);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            op_r      <= 4'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            exp_a     <= 8'd0;
            exp_b     <= 8'd0;
            man_a     <= 24'd0;
            man_b     <= 24'd0;
            sign_z    <= 1'b0;
            exp_z     <= 10'sd0;
            man_z     <= 25'd0;
            z_value_o <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (exec_strobe_i) begin
                        op_r  <= op_i;
                        a_r   <= a_value_i;
                        b_r   <= b_value_i;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_a <= u_sa;
                    sign_b <= u_sbe;
                    exp_a  <= u_ea;
                    exp_b  <= u_eb;
                    man_a  <= {1'b1, u_fa};
                    man_b  <= {1'b1, u_fb};
                    if (special_hit) begin
                        z_value_o <= special_z;
                        state     <= DONE;
                    end else begin
                        state <= OP;
                    end
                end
                OP: begin
                    if (op_r == OP_MUL) begin
                        sign_z <= sign_a ^ sign_b;
                        exp_z  <= prod_e;
                        man_z  <= {1'b0, prod_m};
                        state  <= NORM;
                    end else if (sum == 25'd0) begin
                        z_value_o <= 32'h0000_0000;
                        state     <= DONE;
                    end else begin
                        sign_z <= big_s;
                        exp_z  <= $signed({2'b00, big_e});
                        man_z  <= sum;
                        state  <= NORM;
                    end
                end
                // One left shift per cycle until the hidden bit reaches bit 23
                NORM: begin
                    if (man_z[24]) begin
                        man_z <= man_z >> 1;
                        exp_z <= exp_z + 10'sd1;
                        state <= PACK;
                    end else if (man_z[23]) begin
                        state <= PACK;
                    end else begin
                        man_z <= man_z << 1;
                        exp_z <= exp_z - 10'sd1;
                    end
                end
                PACK: begin
                    if (exp_z >= 10'sd255)
                        z_value_o <= {sign_z, 8'hFF, 23'd0};
                    else if (exp_z <= 10'sd0)
                        z_value_o <= {sign_z, 31'd0};
                    else
                        z_value_o <= {sign_z, exp_z[7:0], man_z[22:0]};
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Self-checking bench for fpu_seq_unit: directed vectors plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_fpu_seq_unit;

    logic        clk;
    logic        reset_i;
    logic [3:0]  op;
    logic [31:0] a_value;
    logic [31:0] b_value;
    logic        exec_strobe;
    logic [31:0] z_value;
    logic        done_strobe;

    int tests_run;
    int tests_failed;

    fpu_seq_unit dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .op_i          (op),
        .a_value_i     (a_value),
        .b_value_i     (b_value),
        .z_value_o     (z_value),
        .exec_strobe_i (exec_strobe),
        .done_strobe_o (done_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int MAX_WAIT = 40;
    localparam int N_DIR    = 13;
    localparam logic [3:0]  DIR_OP  [N_DIR] = '{4'd2, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1,
                                                4'd0, 4'd0, 4'd1, 4'd7, 4'd2, 4'd0};
    localparam logic [31:0] DIR_A   [N_DIR] = '{32'h3F000000, 32'h3F800000, 32'h3F800000,
                                                32'h3F000000, 32'h7F800000, 32'h7F000000,
                                                32'h3F800000, 32'h3FC00000, 32'h7F800000,
                                                32'h00000000, 32'h3F800000, 32'h00800000,
                                                32'h7FC00001};
    localparam logic [31:0] DIR_B   [N_DIR] = '{32'h3F000000, 32'h3F000000, 32'h3F400000,
                                                32'h3F000000, 32'h00000000, 32'h7F000000,
                                                32'h3F7FFFFF, 32'h3FC00000, 32'hFF800000,
                                                32'h3F800000, 32'h3F800000, 32'h00800000,
                                                32'h3F800000};
    localparam logic [31:0] DIR_Z   [N_DIR] = '{32'h3E800000, 32'h3FC00000, 32'h3E800000,
                                                32'h00000000, 32'h7FC00000, 32'h7F800000,
                                                32'h34000000, 32'h40400000, 32'h7FC00000,
                                                32'hBF800000, 32'h00000000, 32'h00000000,
                                                32'h7FC00000};
    localparam int          DIR_LAT [N_DIR] = '{5, 5, 7, 3, 2, 5, 28, 5, 2, 2, 2, 5, 2};

    // Pack sign/exponent/integer mantissa, saturating to Inf or flushing to zero
    function automatic logic [31:0] pack_fp(input bit s, input int e, input longint m);
        logic [22:0] f;
        f = 23'(m & 64'h7FFFFF);
        if (e >= 255)
            return {s, 8'hFF, 23'd0};
        else if (e <= 0)
            return {s, 31'd0};
        else
            return {s, 8'(e), f};
    endfunction

    task automatic model_op(input logic [3:0] mop, input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] mz, output int mlat);
        bit sa, sb, sbe, sl, ss;
        int ea, eb, el, es, e, d;
        longint ma, mb, ml, ms, m, p;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        sa = av[31];
        sb = bv[31];
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        ma = longint'(av[22:0]) + 64'd8388608;
        mb = longint'(bv[22:0]) + 64'd8388608;
        nan_a  = (ea == 255) && (av[22:0] != 0);
        nan_b  = (eb == 255) && (bv[22:0] != 0);
        inf_a  = (ea == 255) && (av[22:0] == 0);
        inf_b  = (eb == 255) && (bv[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        sbe    = sb ^ (mop == 4'd1);
        mz     = 32'h0;
        mlat   = 2;
        if (mop > 4'd2) begin
            mz = 32'h0;
        end else if (nan_a || nan_b) begin
            mz = 32'h7FC00000;
        end else if (mop == 4'd2) begin
            if ((inf_a && zero_b) || (inf_b && zero_a)) mz = 32'h7FC00000;
            else if (inf_a || inf_b) mz = {sa ^ sb, 8'hFF, 23'd0};
            else if (zero_a || zero_b) mz = {sa ^ sb, 31'd0};
            else begin
                p = ma * mb;
                e = ea + eb - 127;
                if (p >= 64'h8000_0000_0000) begin
                    m = p / 64'd16777216;
                    e = e + 1;
                end else begin
                    m = p / 64'd8388608;
                end
                mlat = 5;
                mz = pack_fp(sa ^ sb, e, m);
            end
        end else begin
            if (inf_a && inf_b) mz = (sa != sbe) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
            else if (inf_a) mz = {sa, 8'hFF, 23'd0};
            else if (inf_b) mz = {sbe, 8'hFF, 23'd0};
            else if (zero_a && zero_b) mz = {sa & sbe, 31'd0};
            else if (zero_a) mz = {sbe, bv[30:0]};
            else if (zero_b) mz = av;
            else begin
                if ((ea > eb) || (ea == eb && ma >= mb)) begin
                    el = ea; es = eb; ml = ma; ms = mb; sl = sa; ss = sbe;
                end else begin
                    el = eb; es = ea; ml = mb; ms = ma; sl = sbe; ss = sa;
                end
                d = el - es;
                if (d > 24) ms = 0;
                else ms = ms / (64'd1 << d);
                m = (sl == ss) ? ml + ms : ml - ms;
                e = el;
                if (m == 0) begin
                    mz = 32'h0;
                    mlat = 3;
                end else begin
                    mlat = 5;
                    if (m >= 64'd16777216) begin
                        m = m / 2;
                        e = e + 1;
                    end else begin
                        while (m < 64'd8388608) begin
                            m = m * 2;
                            e = e - 1;
                            mlat = mlat + 1;
                        end
                    end
                    mz = pack_fp(sl, e, m);
                end
            end
        end
    endtask

    function automatic logic [31:0] gen_operand();
        int kind;
        kind = $urandom_range(0, 11);
        case (kind)
            0: return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom_range(0, 8388607))};
            1: return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
            2: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
            3, 4, 5: return {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)),
                             23'($urandom_range(0, 8388607))};
            6: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 8)),
                       23'($urandom_range(0, 8388607))};
            7: return {1'($urandom_range(0, 1)), 8'($urandom_range(245, 254)),
                       23'($urandom_range(0, 8388607))};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] gen_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 6) return 4'd0;
        else if (r < 12) return 4'd1;
        else if (r < 18) return 4'd2;
        else return 4'($urandom_range(3, 15));
    endfunction

    // Issue one request and wait for its done pulse; returns at the DONE-cycle negedge
    task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] zr, output int lat, output bit timed_out);
        @(negedge clk);
        op = o;
        a_value = av;
        b_value = bv;
        exec_strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exec_strobe = 1'b0;
        lat = 1;
        while (!done_strobe && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !done_strobe;
        zr = z_value;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        exec_strobe = 1'b0;
        op = 4'd0;
        a_value = 32'h0;
        b_value = 32'h0;
        #12;
        tests_run++;
        if (z_value !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_z got %h expected 00000000", z_value);
        end
        tests_run++;
        if (done_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done got %b expected 0", done_strobe);
        end
        @(negedge clk);
        reset_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (done_strobe !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_no_done got %b expected 0", done_strobe);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] zr;
        int lat;
        bit to;
        for (int i = 0; i < N_DIR; i++) begin
            do_op(DIR_OP[i], DIR_A[i], DIR_B[i], zr, lat, to);
            tests_run++;
            if (to || zr !== DIR_Z[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_z[%0d] got %h expected %h (timeout=%0d)", i, zr, DIR_Z[i], to);
            end
            tests_run++;
            if (lat !== DIR_LAT[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_lat[%0d] got %0d expected %0d", i, lat, DIR_LAT[i]);
            end
            @(negedge clk);
            tests_run++;
            if (done_strobe !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL directed_pulse[%0d] done still %b expected 0", i, done_strobe);
            end
        end
    endtask

    // (c0-a0)*(b1-a1) - (c1-a1)*(b0-a0) with a=(0,0.5), b=(0.5,0), c=(0,0)
    task automatic test_edge_function();
        logic [31:0] t1, t2, t3, t4, p1, p2, fz, mz;
        int lat, mlat;
        bit to;
        do_op(4'd1, 32'h00000000, 32'h00000000, t1, lat, to);
        do_op(4'd1, 32'h00000000, 32'h3F000000, t2, lat, to);
        do_op(4'd1, 32'h00000000, 32'h3F000000, t3, lat, to);
        do_op(4'd1, 32'h3F000000, 32'h00000000, t4, lat, to);
        model_op(4'd1, 32'h00000000, 32'h3F000000, mz, mlat);
        tests_run++;
        if (t2 !== mz) begin
            tests_failed++;
            $display("[TB] FAIL edge_t2 got %h expected %h", t2, mz);
        end
        do_op(4'd2, t1, t2, p1, lat, to);
        do_op(4'd2, t3, t4, p2, lat, to);
        model_op(4'd2, 32'hBF000000, 32'h3F000000, mz, mlat);
        tests_run++;
        if (p2 !== mz) begin
            tests_failed++;
            $display("[TB] FAIL edge_p2 got %h expected %h", p2, mz);
        end
        do_op(4'd1, p1, p2, fz, lat, to);
        tests_run++;
        if (to || fz !== 32'h3E800000) begin
            tests_failed++;
            $display("[TB] FAIL edge_final got %h expected 3e800000", fz);
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] av, bv, zr, mz;
        int lat, mlat;
        bit to;
        for (int i = 0; i < 400; i++) begin
            o  = gen_op();
            av = gen_operand();
            bv = gen_operand();
            if ($urandom_range(0, 3) == 0) begin
                bv = av ^ 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) bv[31] = ~bv[31];
            end
            model_op(o, av, bv, mz, mlat);
            do_op(o, av, bv, zr, lat, to);
            tests_run++;
            if (to || zr !== mz || lat !== mlat) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h z=%h lat=%0d expected z=%h lat=%0d",
                         i, o, av, bv, zr, lat, mz, mlat);
            end
        end
    endtask

    // Strobe stays high throughout; operands are scrambled while each op runs
    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] mz;
        int lat, mlat;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 4'($urandom_range(0, 2));
            as[i]  = {1'b0, 8'($urandom_range(125, 128)), 23'($urandom_range(0, 8388607))};
            bs[i]  = {1'($urandom_range(0, 1)), 8'($urandom_range(125, 128)), 23'($urandom_range(0, 8388607))};
        end
        @(negedge clk);
        op = ops[0];
        a_value = as[0];
        b_value = bs[0];
        exec_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model_op(ops[i], as[i], bs[i], mz, mlat);
            @(posedge clk);
            @(negedge clk);
            op = gen_op();
            a_value = $urandom;
            b_value = $urandom;
            lat = 1;
            while (!done_strobe && lat < MAX_WAIT) begin
                @(negedge clk);
                lat++;
            end
            tests_run++;
            if (!done_strobe || z_value !== mz || lat !== mlat) begin
                tests_failed++;
                $display("[TB] FAIL b2b[%0d] z=%h lat=%0d expected z=%h lat=%0d", i, z_value, lat, mz, mlat);
            end
            if (i < 3) begin
                op = ops[i+1];
                a_value = as[i+1];
                b_value = bs[i+1];
            end else begin
                exec_strobe = 1'b0;
            end
            @(negedge clk);
            tests_run++;
            if (done_strobe !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_pulse[%0d] done=%b expected 0", i, done_strobe);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] zr, mz, av, bv;
        int lat, mlat, pulses;
        bit to;
        do_op(4'd0, 32'h3F800000, 32'h3F000000, zr, lat, to);
        @(negedge clk);
        op = 4'd1;
        a_value = 32'h3F800000;
        b_value = 32'h3F7FFFFF;
        exec_strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exec_strobe = 1'b0;
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        #1;
        tests_run++;
        if (z_value !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_z got %h expected 00000000", z_value);
        end
        tests_run++;
        if (done_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done got %b expected 0", done_strobe);
        end
        @(negedge clk);
        reset_i = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_strobe) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_aborted saw %0d done pulses expected 0", pulses);
        end
        av = {1'b0, 8'd127, 23'($urandom_range(0, 8388607))};
        bv = {1'b1, 8'd126, 23'($urandom_range(0, 8388607))};
        model_op(4'd0, av, bv, mz, mlat);
        do_op(4'd0, av, bv, zr, lat, to);
        tests_run++;
        if (to || zr !== mz || lat !== mlat) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_op z=%h lat=%0d expected z=%h lat=%0d", zr, lat, mz, mlat);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_edge_function();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
